// File: rtl/ac_motor_svpwm_timer_if.sv
// Control/status bundle between the SVPWM timer and its host: shadow-load inputs and period outputs.
interface ac_motor_svpwm_timer_if #(
    parameter int W = 12
);
    logic         EN;
    logic         LOAD;
    logic [2:0]   SECTOR_IN;
    logic [W-1:0] T1;
    logic [W-1:0] T2;
    logic [W-1:0] T_HALF;
    logic [2:0]   SECTOR;
    logic         U_0;
    logic         U_1;
    logic         U_2;
    logic         U_7;
    logic         PERIOD_START;
    logic         SAT;
    logic         SEC_ERR;

    modport master (
        output EN, LOAD, SECTOR_IN, T1, T2, T_HALF,
        input  SECTOR, U_0, U_1, U_2, U_7, PERIOD_START, SAT, SEC_ERR
    );

    modport slave (
        input  EN, LOAD, SECTOR_IN, T1, T2, T_HALF,
        output SECTOR, U_0, U_1, U_2, U_7, PERIOD_START, SAT, SEC_ERR
    );
endinterface

// File: rtl/ac_motor_svpwm_timer.sv
// Symmetric SVPWM interval timer: Z0/A1/A2/Z7 up then down, 2*T_HALF clocks per period.
// Outputs registered, change on the same edge as the state; no backpressure, EN low idles.
module ac_motor_svpwm_timer #(
    parameter int W = 12
) (
    input  logic                     CLK,
    input  logic                     RST,
    ac_motor_svpwm_timer_if.slave    bus
);
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        Z0_UP = 4'd1,
        A1_UP = 4'd2,
        A2_UP = 4'd3,
        Z7_UP = 4'd4,
        Z7_DN = 4'd5,
        A2_DN = 4'd6,
        A1_DN = 4'd7,
        Z0_DN = 4'd8
    } state_t;

    function automatic logic [W-1:0] len_at(input logic [3:0] idx, input logic [W-1:0] l0,
                                            input logic [W-1:0] l1, input logic [W-1:0] l2,
                                            input logic [W-1:0] l7);
        case (idx)
            4'd1, 4'd8: len_at = l0;
            4'd2, 4'd7: len_at = l1;
            4'd3, 4'd6: len_at = l2;
            4'd4, 4'd5: len_at = l7;
            default:    len_at = '0;
        endcase
    endfunction

    // First state at or after 'from' with a nonzero dwell; 0 means the period is exhausted.
    function automatic logic [3:0] seek(input logic [3:0] from, input logic [W-1:0] l0,
                                        input logic [W-1:0] l1, input logic [W-1:0] l2,
                                        input logic [W-1:0] l7);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 8; k >= 1; k--) begin
            if (4'(k) >= from && len_at(4'(k), l0, l1, l2, l7) != '0) r = 4'(k);
        end
        return r;
    endfunction

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [2:0]   sh_sector;
    logic [W-1:0] sh_t1, sh_t2, sh_thalf;
    logic [W-1:0] a_l0, a_l1, a_l2, a_l7, a_thalf;
    logic [2:0]   sector_q;
    logic         sat_q, err_q, ps_q, u0_q, u1_q, u2_q, u7_q;

    logic [W:0]   sum;
    logic [W-1:0] n_t1, n_t2, t0, n_l0, n_l1, n_l2, n_l7;
    logic         n_sat, n_err;

    // Dwell times the next period would use if the shadow were copied now.
    always_comb begin
        sum   = {1'b0, sh_t1} + {1'b0, sh_t2};
        n_t1  = sh_t1;
        n_t2  = sh_t2;
        n_sat = 1'b0;
        if (sh_t1 >= sh_thalf) begin
            n_t1  = sh_thalf;
            n_t2  = '0;
            n_sat = 1'b1;
        end else if (sum > {1'b0, sh_thalf}) begin
            n_t2  = sh_thalf - sh_t1;
            n_sat = 1'b1;
        end
        t0    = sh_thalf - n_t1 - n_t2;
        n_err = (sh_sector > 3'd5);
        if (n_err) begin
            n_l0 = sh_thalf;
            n_l1 = '0;
            n_l2 = '0;
            n_l7 = '0;
        end else begin
            n_l0 = t0 >> 1;
            n_l1 = n_t1;
            n_l2 = n_t2;
            n_l7 = t0 - (t0 >> 1);
        end
    end

    logic [W-1:0] cur_len;
    logic [3:0]   nxt_idx, first_idx;
    logic         copy, ps_n;

    always_comb begin
        cur_len   = len_at(state, a_l0, a_l1, a_l2, a_l7);
        nxt_idx   = seek(4'(state) + 4'd1, a_l0, a_l1, a_l2, a_l7);
        first_idx = seek(4'd1, n_l0, n_l1, n_l2, n_l7);
        state_n   = state;
        cnt_n     = cnt + W'(1);
        copy      = 1'b0;
        if (!bus.EN) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (state == IDLE || a_thalf == '0) begin
            copy = 1'b1;
        end else if (cnt == cur_len - W'(1)) begin
            cnt_n = '0;
            if (nxt_idx == 4'd0) copy = 1'b1;
            else                 state_n = state_t'(nxt_idx);
        end
        // A zero-length period parks in Z0_UP and re-copies the shadow every cycle.
        if (copy) begin
            cnt_n   = '0;
            state_n = (sh_thalf == '0) ? Z0_UP : state_t'(first_idx);
        end
        ps_n = copy && (sh_thalf != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_sector <= '0;
            sh_t1     <= '0;
            sh_t2     <= '0;
            sh_thalf  <= '0;
            a_l0      <= '0;
            a_l1      <= '0;
            a_l2      <= '0;
            a_l7      <= '0;
            a_thalf   <= '0;
            sector_q  <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            ps_q      <= 1'b0;
            u0_q      <= 1'b0;
            u1_q      <= 1'b0;
            u2_q      <= 1'b0;
            u7_q      <= 1'b0;
        end else begin
            if (bus.LOAD) begin
                sh_sector <= bus.SECTOR_IN;
                sh_t1     <= bus.T1;
                sh_t2     <= bus.T2;
                sh_thalf  <= bus.T_HALF;
            end
            if (copy) begin
                a_l0     <= n_l0;
                a_l1     <= n_l1;
                a_l2     <= n_l2;
                a_l7     <= n_l7;
                a_thalf  <= sh_thalf;
                sector_q <= n_err ? 3'd0 : sh_sector;
                sat_q    <= n_sat;
                err_q    <= n_err;
            end
            state <= state_n;
            cnt   <= cnt_n;
            ps_q  <= ps_n;
            u0_q  <= (state_n == Z0_UP) || (state_n == Z0_DN);
            u1_q  <= (state_n == A1_UP) || (state_n == A1_DN);
            u2_q  <= (state_n == A2_UP) || (state_n == A2_DN);
            u7_q  <= (state_n == Z7_UP) || (state_n == Z7_DN);
        end
    end

    assign bus.SECTOR       = sector_q;
    assign bus.SAT          = sat_q;
    assign bus.SEC_ERR      = err_q;
    assign bus.PERIOD_START = ps_q;
    assign bus.U_0          = u0_q;
    assign bus.U_1          = u1_q;
    assign bus.U_2          = u2_q;
    assign bus.U_7          = u7_q;
endmodule
